// File: rtl/ram_param.sv
// Parameterised single-port register-file RAM with a one-cycle read latency and a
// hardware clear sweep that zeroes every word, one word per clock.
module ram_param #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned ADDR_W = 2
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              en,
  input  logic              readWrite,
  input  logic [ADDR_W-1:0] address,
  input  logic [WIDTH-1:0]  x,
  input  logic              clr_req,
  output logic [WIDTH-1:0]  s,
  output logic              valid,
  output logic              busy,
  output logic              done
);

  localparam int unsigned       DEPTH    = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

  typedef enum logic [0:0] {
    StIdle,
    StSweep
  } state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0]   mem_q [DEPTH];
  logic [WIDTH-1:0]   mem_d [DEPTH];
  logic [WIDTH-1:0]   s_q, s_d;
  logic               valid_q, valid_d;
  logic               done_q, done_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mem_d   = mem_q;
    s_d     = s_q;
    valid_d = 1'b0;
    done_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        // A clear request wins over a simultaneous access; the access is dropped.
        if (clr_req) begin
          state_d = StSweep;
          cnt_d   = '0;
        end else if (en) begin
          if (readWrite) begin
            mem_d[address] = x;
          end else begin
            s_d     = mem_q[address];
            valid_d = 1'b1;
          end
        end
      end
      StSweep: begin
        mem_d[cnt_q] = '0;
        if (cnt_q == LastAddr) begin
          state_d = StIdle;
          done_d  = 1'b1;
          s_d     = '0;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      s_q     <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign s     = s_q;
  assign valid = valid_q;
  assign done  = done_q;
  assign busy  = (state_q == StSweep);

endmodule

// File: tb/tb_ram_param.sv
// Directed bench for ram_param (WIDTH=8, ADDR_W=2): a behavioural model predicts every
// cycle, and read data is checked through a scoreboard queue.
module tb_ram_param;

  logic       clk = 1'b0;
  logic       clear = 1'b0;
  logic       en = 1'b0;
  logic       readWrite = 1'b0;
  logic [1:0] address = '0;
  logic [7:0] x = '0;
  logic       clr_req = 1'b0;
  logic [7:0] s;
  logic       valid, busy, done;

  int total = 0;
  int bad   = 0;

  logic [7:0] mem_m [4];
  logic [7:0] s_m;
  logic       busy_m, done_m;
  logic [1:0] cnt_m;
  logic [7:0] sb [$];
  int         done_cnt;
  int         busy_cycles;

  ram_param #(.WIDTH(8), .ADDR_W(2)) dut (
    .clk      (clk),
    .clear    (clear),
    .en       (en),
    .readWrite(readWrite),
    .address  (address),
    .x        (x),
    .clr_req  (clr_req),
    .s        (s),
    .valid    (valid),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) mem_m[i] = 8'h00;
    s_m    = 8'h00;
    busy_m = 1'b0;
    done_m = 1'b0;
    cnt_m  = 2'd0;
    sb.delete();
  endtask

  // Drive one cycle, advance the model, then check every output 1 ns after the edge.
  task automatic step(input logic e, input logic rw, input logic [1:0] a, input logic [7:0] d,
                      input logic cr, input string tag);
    logic rd;
    logic [7:0] exp_s;
    rd = 1'b0;
    en = e; readWrite = rw; address = a; x = d; clr_req = cr;
    done_m = 1'b0;
    if (!busy_m) begin
      if (cr) begin
        busy_m = 1'b1;
        cnt_m  = 2'd0;
      end else if (e) begin
        if (rw) mem_m[a] = d;
        else begin
          sb.push_back(mem_m[a]);
          s_m = mem_m[a];
          rd  = 1'b1;
        end
      end
    end else begin
      mem_m[cnt_m] = 8'h00;
      if (cnt_m == 2'd3) begin
        busy_m = 1'b0;
        done_m = 1'b1;
        s_m    = 8'h00;
      end else cnt_m = cnt_m + 2'd1;
    end
    @(posedge clk);
    #1;
    en = 1'b0; readWrite = 1'b0; clr_req = 1'b0;
    chk({tag, ".valid"}, 32'(valid), 32'(rd));
    if (rd && sb.size() > 0) begin
      exp_s = sb.pop_front();
      chk({tag, ".rdata"}, 32'(s), 32'(exp_s));
    end
    chk({tag, ".s"}, 32'(s), 32'(s_m));
    chk({tag, ".busy"}, 32'(busy), 32'(busy_m));
    chk({tag, ".done"}, 32'(done), 32'(done_m));
    if (done) done_cnt++;
    if (busy) busy_cycles++;
  endtask

  initial begin
    model_reset();
    #2;
    chk("reset.s", 32'(s), 32'h0);
    chk("reset.valid", 32'(valid), 32'h0);
    chk("reset.busy", 32'(busy), 32'h0);
    chk("reset.done", 32'(done), 32'h0);
    @(posedge clk); #1;
    clear = 1'b1;

    // Reset contents read back as zero
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 2'(i), 8'h00, 1'b0, "rd_reset");

    // Basic writes, then reads in reverse order
    step(1'b1, 1'b1, 2'd0, 8'hCE, 1'b0, "wr0");
    step(1'b1, 1'b1, 2'd1, 8'hBC, 1'b0, "wr1");
    step(1'b1, 1'b0, 2'd1, 8'h00, 1'b0, "rd1");
    step(1'b1, 1'b0, 2'd0, 8'h00, 1'b0, "rd0");
    step(1'b0, 1'b0, 2'd0, 8'h00, 1'b0, "hold");

    // Read immediately after write
    step(1'b1, 1'b1, 2'd3, 8'h5A, 1'b0, "wr3");
    step(1'b1, 1'b0, 2'd3, 8'h00, 1'b0, "rd3_raw");
    chk("raw.data", 32'(s), 32'h5A);

    // Full sweep with a colliding write request
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 2'(i), 8'hFF, 1'b0, "fillFF");
    done_cnt = 0; busy_cycles = 0;
    step(1'b1, 1'b1, 2'd2, 8'h11, 1'b1, "sweep_start");
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 2'd0, 8'h00, 1'b0, "sweep");
    chk("sweep.busy_cycles", 32'(busy_cycles), 32'd4);
    chk("sweep.done_pulses", 32'(done_cnt), 32'd1);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 2'(i), 8'h00, 1'b0, "rd_after_sweep");

    // Requests during a sweep are ignored
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 2'(i), 8'h3C, 1'b0, "fill3C");
    done_cnt = 0; busy_cycles = 0;
    step(1'b0, 1'b0, 2'd0, 8'h00, 1'b1, "sweep2_start");
    step(1'b1, 1'b0, 2'd1, 8'h00, 1'b0, "sweep2_read");
    step(1'b0, 1'b0, 2'd0, 8'h00, 1'b1, "sweep2_reclr");
    step(1'b1, 1'b1, 2'd0, 8'h77, 1'b0, "sweep2_write");
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 2'd0, 8'h00, 1'b0, "sweep2");
    chk("sweep2.busy_cycles", 32'(busy_cycles), 32'd4);
    chk("sweep2.done_pulses", 32'(done_cnt), 32'd1);
    step(1'b1, 1'b0, 2'd0, 8'h00, 1'b0, "rd_after_sweep2");

    // Reset aborts a sweep; inputs during reset do nothing
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 2'(i), 8'hA5, 1'b0, "fillA5");
    step(1'b1, 1'b0, 2'd2, 8'h00, 1'b0, "rdA5");
    step(1'b0, 1'b0, 2'd0, 8'h00, 1'b1, "sweep3_start");
    step(1'b0, 1'b0, 2'd0, 8'h00, 1'b0, "sweep3_c1");
    step(1'b0, 1'b0, 2'd0, 8'h00, 1'b0, "sweep3_c2");
    #2;
    clear = 1'b0;
    #1;
    chk("abort.s", 32'(s), 32'h0);
    chk("abort.valid", 32'(valid), 32'h0);
    chk("abort.busy", 32'(busy), 32'h0);
    chk("abort.done", 32'(done), 32'h0);
    model_reset();
    en = 1'b1; readWrite = 1'b1; address = 2'd1; x = 8'h99; clr_req = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (done) done_cnt++;
    end
    chk("abort.no_done", 32'(done_cnt), 32'd0);
    chk("abort.busy_in_reset", 32'(busy), 32'h0);
    en = 1'b0; readWrite = 1'b0; clr_req = 1'b0;
    clear = 1'b1;
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 2'(i), 8'h00, 1'b0, "rd_after_abort");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ram_param.md
RAM_PARAM -- requirements
Module: ram_param

Interface
REQ-001 Parameter WIDTH, default 8: data word width in bits, legal range 1 to 32.
REQ-002 Parameter ADDR_W, default 2: address width in bits; depth DEPTH = 2**ADDR_W words, legal ADDR_W range 1 to 6.
REQ-003 clk  input  1  single clock; all state changes on rising edge except reset.
REQ-004 clear  input  1  asynchronous active-low reset; 0 resets immediately, release is synchronous to clk.
REQ-005 en  input  1  access request; sampled on rising clk.
REQ-006 readWrite  input  1  access type when en=1: 1 = write, 0 = read.
REQ-007 address  input  ADDR_W  word address for the access.
REQ-008 x  input  WIDTH  write data.
REQ-009 clr_req  input  1  start synchronous clear sweep of the array.
REQ-010 s  output  WIDTH  registered read data.
REQ-011 valid  output  1  1-cycle pulse: s holds fresh read data.
REQ-012 busy  output  1  1 while sweep in progress.
REQ-013 done  output  1  1-cycle pulse on sweep completion.

Function
REQ-014 Storage SHALL be DEPTH words of WIDTH bits, addressable over the full ADDR_W range; no out-of-range addresses exist.
REQ-015 Write: en=1, readWrite=1, busy=0 at rising edge -> mem[address] <= x; s and valid unchanged (valid=0 that cycle).
REQ-016 Read: en=1, readWrite=0, busy=0 at rising edge -> s <= mem[address] and valid=1 after that same edge (1-cycle latency).
REQ-017 s SHALL hold its last read value until the next read, sweep completion, or reset.
REQ-018 valid SHALL be 0 in every cycle not immediately following an accepted read.
REQ-019 A read of an address in the cycle after a write to it SHALL return the newly written data.
REQ-020 FSM states: IDLE, SWEEP; reset state IDLE.
REQ-021 IDLE -> SWEEP when clr_req=1 at rising edge; sweep counter loads 0; busy=1 from that edge.
REQ-022 In SWEEP, each rising edge writes 0 to mem[counter] and increments the counter; the word at DEPTH-1 is cleared on the DEPTH-th edge of SWEEP.
REQ-023 After clearing word DEPTH-1: state -> IDLE, busy=0, done=1 for exactly one cycle, s <= 0; the sweep takes exactly DEPTH cycles of busy=1.
REQ-024 While busy=1, en and clr_req SHALL be ignored: no write, no read, no valid, no restart.
REQ-025 clr_req=1 and en=1 at the same edge in IDLE: sweep starts, the access is dropped (no write, valid stays 0).
REQ-026 Counter SHALL be ADDR_W bits and SHALL NOT wrap into a second pass; the terminal count ends the sweep.

Reset
REQ-027 clear=0 SHALL immediately force: all DEPTH words = 0, s = 0, valid = 0, busy = 0, done = 0, state IDLE, counter 0.
REQ-028 clear=0 during SWEEP SHALL abort the sweep with no done pulse; after release, the block is IDLE and accepts accesses on the first rising edge.
REQ-029 Inputs sampled on an edge where clear=0 SHALL have no effect.

Verification (WIDTH=8, ADDR_W=2)
REQ-030 Reset then read addr 0..3 -> each read returns s=8'h00 with valid=1 one cycle after its request.
REQ-031 Write 8'hCE to addr 0 and 8'hBC to addr 1, then read 1, 0 -> s=8'hBC then 8'hCE, each valid for exactly one cycle.
REQ-032 Write 8'h5A to addr 3, read addr 3 on the very next edge -> s=8'h5A, valid=1.
REQ-033 Fill all 4 words with 8'hFF, pulse clr_req with en=1, readWrite=1, x=8'h11 -> busy=1 for 4 cycles, done=1 for 1 cycle, s=8'h00; reads of all addresses give 8'h00, no 8'h11 anywhere.
REQ-034 During a sweep, issue a read and a second clr_req -> valid stays 0, sweep length stays 4 cycles, a single done pulse.
REQ-035 Fill with 8'hA5, start sweep, drive clear=0 after 2 sweep cycles -> all outputs 0 immediately, no done pulse, all words read back 8'h00 after release.
